// File: rtl/stepper_motion_controller.sv
// Stepper motion controller: accepts move commands, sequences full-step coil
// phases with a linear accel/cruise/decel interval profile, and tracks the
// absolute position of the axis.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// ACCEL  | interval shrinking by RAMP_DEC per step toward cruise
// CRUISE | stepping at the cruise interval
// DECEL  | interval growing by RAMP_DEC per step toward START_PERIOD
// DONE   | one-cycle end-of-move marker, done_pulse high
module stepper_motion_controller #(
    parameter int STEP_W       = 16,
    parameter int CNT_W        = 32,
    parameter int START_PERIOD = 100000,
    parameter int MIN_PERIOD   = 2,
    parameter int RAMP_DEC     = 1000,
    parameter int HOLD_TORQUE  = 1
) (
    input  logic              clock_clk,
    input  logic              reset_low,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic              cmd_dir,
    input  logic [CNT_W-1:0]  cmd_period,
    input  logic              abort,
    output logic [3:0]        phase_out,
    output logic [1:0]        drive_en,
    output logic              busy,
    output logic              done_pulse,
    output logic [31:0]       position
);

    typedef enum logic [2:0] {IDLE, ACCEL, CRUISE, DECEL, DONE} state_t;

    // One extra bit so ramp sums never wrap.
    localparam logic [CNT_W:0] START_X = (CNT_W+1)'(START_PERIOD);
    localparam logic [CNT_W:0] MIN_X   = (CNT_W+1)'(MIN_PERIOD);
    localparam logic [CNT_W:0] RAMP_X  = (CNT_W+1)'(RAMP_DEC);

    state_t            state, state_next;
    logic [1:0]        idx, idx_next;
    logic              dir, dir_next;
    logic [CNT_W-1:0]  cur, cur_next;
    logic [CNT_W-1:0]  cruise, cruise_next;
    logic [CNT_W-1:0]  timer, timer_next;
    logic [STEP_W-1:0] steps_left, steps_next;
    logic [STEP_W-1:0] ramp_cnt, ramp_next;
    logic [3:0]        phase_next;
    logic [1:0]        drive_next;
    logic [31:0]       position_next;
    logic              done_next;

    function automatic logic [3:0] phase_of(input logic [1:0] i);
        phase_of = 4'b0001 << i;
    endfunction

    // max(c - RAMP_DEC, floor_p) without underflow
    function automatic logic [CNT_W-1:0] ramp_down(input logic [CNT_W-1:0] c,
                                                   input logic [CNT_W-1:0] floor_p);
        logic [CNT_W:0] lim;
        lim = {1'b0, floor_p} + RAMP_X;
        if ({1'b0, c} > lim) ramp_down = c - RAMP_X[CNT_W-1:0];
        else                 ramp_down = floor_p;
    endfunction

    // min(c + RAMP_DEC, START_PERIOD) without overflow
    function automatic logic [CNT_W-1:0] ramp_up(input logic [CNT_W-1:0] c);
        logic [CNT_W:0] sum;
        sum = {1'b0, c} + RAMP_X;
        if (sum < START_X) ramp_up = sum[CNT_W-1:0];
        else               ramp_up = START_X[CNT_W-1:0];
    endfunction

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // State and datapath registers; reset drops the coils immediately.
    always_ff @(posedge clock_clk or negedge reset_low) begin
        if (!reset_low) begin
            state      <= IDLE;
            idx        <= '0;
            dir        <= 1'b0;
            cur        <= '0;
            cruise     <= '0;
            timer      <= '0;
            steps_left <= '0;
            ramp_cnt   <= '0;
            phase_out  <= '0;
            drive_en   <= '0;
            position   <= '0;
            done_pulse <= 1'b0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            dir        <= dir_next;
            cur        <= cur_next;
            cruise     <= cruise_next;
            timer      <= timer_next;
            steps_left <= steps_next;
            ramp_cnt   <= ramp_next;
            phase_out  <= phase_next;
            drive_en   <= drive_next;
            position   <= position_next;
            done_pulse <= done_next;
        end
    end

    // Next-state and datapath: step event first, then abort on the new values.
    always_comb begin
        state_next    = state;
        idx_next      = idx;
        dir_next      = dir;
        cur_next      = cur;
        cruise_next   = cruise;
        timer_next    = timer;
        steps_next    = steps_left;
        ramp_next     = ramp_cnt;
        phase_next    = phase_out;
        drive_next    = drive_en;
        position_next = position;
        done_next     = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_steps == '0) begin
                        done_next = 1'b1;
                    end else begin
                        cruise_next = ({1'b0, cmd_period} > MIN_X) ? cmd_period
                                                                   : MIN_X[CNT_W-1:0];
                        cur_next    = (START_X > {1'b0, cruise_next}) ? START_X[CNT_W-1:0]
                                                                      : cruise_next;
                        dir_next    = cmd_dir;
                        steps_next  = cmd_steps;
                        ramp_next   = '0;
                        timer_next  = '0;
                        drive_next  = 2'b11;
                        phase_next  = phase_of(idx);
                        state_next  = (cur_next == cruise_next) ? CRUISE : ACCEL;
                    end
                end
            end
            ACCEL, CRUISE, DECEL: begin
                timer_next = timer + CNT_W'(1);
                if (timer == cur - CNT_W'(1)) begin
                    timer_next    = '0;
                    idx_next      = dir ? idx + 2'd1 : idx - 2'd1;
                    phase_next    = phase_of(idx_next);
                    position_next = dir ? position + 32'd1 : position - 32'd1;
                    steps_next    = steps_left - STEP_W'(1);
                    if (steps_next == '0) begin
                        state_next = DONE;
                    end else if (state == ACCEL) begin
                        ramp_next = ramp_cnt + STEP_W'(1);
                        cur_next  = ramp_down(cur, cruise);
                        if (steps_next <= ramp_next) begin
                            state_next = DECEL;
                            cur_next   = ramp_up(cur);
                        end else if (cur_next == cruise) begin
                            state_next = CRUISE;
                        end
                    end else if (state == CRUISE) begin
                        if (steps_next <= ramp_cnt) begin
                            state_next = DECEL;
                            cur_next   = ramp_up(cur);
                        end
                    end else begin
                        ramp_next = (ramp_cnt == '0) ? '0 : ramp_cnt - STEP_W'(1);
                        cur_next  = ramp_up(cur);
                    end
                end
                // Abort trims the remaining steps to what the ramp-down needs.
                if (abort && (state_next == ACCEL || state_next == CRUISE)) begin
                    if (ramp_next < steps_next) steps_next = ramp_next;
                    if (steps_next == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next = DECEL;
                        cur_next   = ramp_up(cur);
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                if (HOLD_TORQUE != 0) begin
                    drive_next = 2'b11;
                end else begin
                    drive_next = 2'b00;
                    phase_next = 4'b0000;
                end
            end
            default: state_next = IDLE;
        endcase

        if (state_next == DONE) done_next = 1'b1;
    end

endmodule

// File: tb/tb_stepper_motion_controller.sv
// Directed bench for stepper_motion_controller with a short ramp profile.
// Expected step events (phase, position, interval) are queued as each command
// is issued and checked as the DUT steps.
module tb_stepper_motion_controller;

    logic        clock_clk = 1'b0;
    logic        reset_low;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_steps;
    logic        cmd_dir;
    logic [31:0] cmd_period;
    logic        abort;
    logic [3:0]  phase_out;
    logic [1:0]  drive_en;
    logic        busy;
    logic        done_pulse;
    logic [31:0] position;

    stepper_motion_controller #(
        .STEP_W(16), .CNT_W(32), .START_PERIOD(10), .MIN_PERIOD(2),
        .RAMP_DEC(2), .HOLD_TORQUE(1)
    ) dut (
        .clock_clk(clock_clk), .reset_low(reset_low), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_steps(cmd_steps), .cmd_dir(cmd_dir),
        .cmd_period(cmd_period), .abort(abort), .phase_out(phase_out),
        .drive_en(drive_en), .busy(busy), .done_pulse(done_pulse),
        .position(position)
    );

    always #5 clock_clk = ~clock_clk;

    typedef struct {
        logic [3:0]  ph;
        logic [31:0] pos;
        int          iv;
    } step_t;

    step_t       exp_q[$];
    int          n_asserts = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          mark = 0;
    int          last_evt = 0;
    int          done_cnt = 0;
    logic [31:0] pos_prev = '0;
    logic        busy_prev = 1'b0;
    logic [1:0]  tb_idx = '0;
    logic [31:0] tb_pos = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_step(input logic d, input int iv);
        step_t       s;
        logic [3:0]  one;
        one    = 4'b0001;
        tb_idx = d ? tb_idx + 2'd1 : tb_idx - 2'd1;
        tb_pos = d ? tb_pos + 32'd1 : tb_pos - 32'd1;
        s.ph   = one << tb_idx;
        s.pos  = tb_pos;
        s.iv   = iv;
        exp_q.push_back(s);
    endtask

    // Advance to the next falling edge and score any step event seen there.
    task automatic tick();
        step_t s;
        @(negedge clock_clk);
        cyc++;
        if (!reset_low) begin
            pos_prev  = position;
            busy_prev = busy;
        end else begin
            if (busy && !busy_prev) mark = cyc;
            if (position !== pos_prev) begin
                n_asserts++;
                assert (exp_q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_step observed_position=%0d expected_queue_entries=1+",
                           position);
                end
                if (exp_q.size() > 0) begin
                    s = exp_q.pop_front();
                    check("step_phase", {28'd0, phase_out}, {28'd0, s.ph});
                    check("step_position", position, s.pos);
                    check("step_interval", cyc - mark, s.iv);
                end
                mark     = cyc;
                last_evt = cyc;
            end
            if (done_pulse) done_cnt++;
            pos_prev  = position;
            busy_prev = busy;
        end
    endtask

    task automatic do_reset();
        reset_low = 1'b0;
        exp_q.delete();
        tb_idx = '0;
        tb_pos = '0;
        tick();
        tick();
        reset_low = 1'b1;
        tick();
    endtask

    task automatic send(input logic [15:0] steps, input logic d, input logic [31:0] period);
        cmd_steps  = steps;
        cmd_dir    = d;
        cmd_period = period;
        cmd_valid  = 1'b1;
        tick();
        cmd_valid  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int start;
        bit seen;
        start = done_cnt;
        seen  = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (done_cnt != start) seen = 1'b1;
        end
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        tick();
    endtask

    task automatic wait_pos(input string tag, input logic [31:0] target, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (position == target) seen = 1'b1;
        end
        check({tag, "_pos_reached"}, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        int d0;
        int c0;
        int iv_prof[10];
        int iv_abort[8];
        iv_prof  = '{10, 8, 6, 4, 4, 4, 4, 6, 8, 10};
        iv_abort = '{10, 8, 6, 4, 4, 6, 8, 10};

        reset_low  = 1'b0;
        cmd_valid  = 1'b0;
        cmd_steps  = '0;
        cmd_dir    = 1'b0;
        cmd_period = '0;
        abort      = 1'b0;

        // Reset values
        do_reset();
        check("rst_phase", {28'd0, phase_out}, 32'h0);
        check("rst_drive", {30'd0, drive_en}, 32'h0);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done_pulse}, 32'd0);
        check("rst_position", position, 32'd0);

        // Forward 3 steps at the start interval
        for (int i = 0; i < 3; i++) push_step(1'b1, 10);
        d0 = done_cnt;
        send(16'd3, 1'b1, 32'd10);
        check("m1_start_phase", {28'd0, phase_out}, 32'h1);
        check("m1_start_drive", {30'd0, drive_en}, 32'h3);
        check("m1_start_busy", {31'd0, busy}, 32'd1);
        wait_done("m1", 200);
        check("m1_done_count", done_cnt - d0, 32'd1);
        check("m1_position", position, 32'd3);
        check("m1_phase", {28'd0, phase_out}, 32'h8);
        check("m1_drive_hold", {30'd0, drive_en}, 32'h3);
        check("m1_idle_ready", {31'd0, cmd_ready}, 32'd1);

        // Reverse 2 steps; a command offered mid-move must be ignored
        for (int i = 0; i < 2; i++) push_step(1'b0, 10);
        d0 = done_cnt;
        send(16'd2, 1'b0, 32'd10);
        for (int i = 0; i < 3; i++) tick();
        cmd_steps = 16'd7;
        cmd_dir   = 1'b1;
        cmd_valid = 1'b1;
        tick();
        check("m2_ready_low", {31'd0, cmd_ready}, 32'd0);
        cmd_valid = 1'b0;
        wait_done("m2", 200);
        check("m2_done_count", done_cnt - d0, 32'd1);
        check("m2_position", position, 32'd1);
        check("m2_phase", {28'd0, phase_out}, 32'h2);
        check("m2_queue_empty", exp_q.size(), 32'd0);

        // Zero-step command: pulse only
        send(16'd0, 1'b1, 32'd10);
        check("z_done", {31'd0, done_pulse}, 32'd1);
        check("z_busy", {31'd0, busy}, 32'd0);
        check("z_phase", {28'd0, phase_out}, 32'h2);
        check("z_position", position, 32'd1);
        tick();
        check("z_done_clear", {31'd0, done_pulse}, 32'd0);
        check("z_busy_after", {31'd0, busy}, 32'd0);

        // Full accel/cruise/decel profile
        do_reset();
        foreach (iv_prof[i]) push_step(1'b1, iv_prof[i]);
        d0 = done_cnt;
        send(16'd10, 1'b1, 32'd4);
        c0 = cyc;
        wait_done("m3", 300);
        check("m3_done_count", done_cnt - d0, 32'd1);
        check("m3_position", position, 32'd10);
        check("m3_total_clocks", last_evt - c0, 32'd64);
        check("m3_queue_empty", exp_q.size(), 32'd0);

        // Abort one cycle after the 5th step
        do_reset();
        foreach (iv_abort[i]) push_step(1'b1, iv_abort[i]);
        d0 = done_cnt;
        send(16'd100, 1'b1, 32'd4);
        wait_pos("m4", 32'd5, 200);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done("m4", 200);
        check("m4_done_count", done_cnt - d0, 32'd1);
        check("m4_position", position, 32'd8);
        check("m4_queue_empty", exp_q.size(), 32'd0);

        // Abort with no ramp built up ends the move without stepping
        d0 = done_cnt;
        send(16'd5, 1'b1, 32'd10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("m5_done", {31'd0, done_pulse}, 32'd1);
        check("m5_position", position, 32'd8);
        tick();
        check("m5_busy", {31'd0, busy}, 32'd0);
        check("m5_done_count", done_cnt - d0, 32'd1);
        check("m5_phase", {28'd0, phase_out}, 32'h1);

        // Asynchronous reset during cruise
        for (int i = 0; i < 2; i++) push_step(1'b1, 10);
        send(16'd50, 1'b1, 32'd10);
        wait_pos("m6", 32'd10, 100);
        tick();
        #2;
        reset_low = 1'b0;
        #1;
        check("ar_phase", {28'd0, phase_out}, 32'h0);
        check("ar_drive", {30'd0, drive_en}, 32'h0);
        check("ar_position", position, 32'd0);
        check("ar_ready", {31'd0, cmd_ready}, 32'd1);
        check("ar_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        tb_idx = '0;
        tb_pos = '0;
        tick();
        tick();
        reset_low = 1'b1;
        tick();
        tick();
        check("ar_position_after", position, 32'd0);
        check("ar_busy_after", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
